// File: rtl/hall_conditioner.sv
// Hall-sensor conditioner: 2-FF sync, stability filter, sequence/direction check,
// commutation period and stall detection. Define HALL_INV_EN for inverted-sense sensors.
module hall_conditioner #(
  parameter int unsigned FILT_CYCLES = 16,
  parameter int unsigned PERIOD_W    = 20,
  parameter int unsigned STALL_LIMIT = 2**20 - 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          hall_raw,
  output logic [2:0]          h,
  output logic                hall_valid,
  output logic                dir_obs,
  output logic [PERIOD_W-1:0] period,
  output logic                period_stb,
  output logic                stall,
  output logic                seq_err
);

  localparam int unsigned FCW = (FILT_CYCLES > 2) ? $clog2(FILT_CYCLES) : 1;
  localparam logic [FCW-1:0]      FILT_ACC = FCW'(FILT_CYCLES - 2);
  localparam logic [FCW-1:0]      FILT_MAX = FCW'(FILT_CYCLES - 1);
  localparam logic [PERIOD_W-1:0] LIM      = PERIOD_W'(STALL_LIMIT);
  localparam logic [PERIOD_W-1:0] LIM_M1   = PERIOD_W'(STALL_LIMIT - 1);

  typedef enum logic [1:0] {ST_INIT, ST_SYNC, ST_RUN} state_t;

  function automatic logic [2:0] fwd_of(input logic [2:0] c);
    case (c)
      3'd1:    fwd_of = 3'd3;
      3'd3:    fwd_of = 3'd2;
      3'd2:    fwd_of = 3'd6;
      3'd6:    fwd_of = 3'd4;
      3'd4:    fwd_of = 3'd5;
      3'd5:    fwd_of = 3'd1;
      default: fwd_of = 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] rev_of(input logic [2:0] c);
    case (c)
      3'd3:    rev_of = 3'd1;
      3'd2:    rev_of = 3'd3;
      3'd6:    rev_of = 3'd2;
      3'd4:    rev_of = 3'd6;
      3'd5:    rev_of = 3'd4;
      3'd1:    rev_of = 3'd5;
      default: rev_of = 3'd0;
    endcase
  endfunction

  logic [2:0]          w_raw;
  logic [2:0]          r_sync1, r_sync2, r_cand;
  logic [FCW-1:0]      r_fcnt;
  logic [PERIOD_W-1:0] r_pcnt;
  state_t              r_state, w_state_nxt;

  logic w_acc, w_new_v, w_is_fwd, w_is_rev;
  logic w_legal, w_illegal, w_entry, w_exit, w_vedge, w_stall_hit;
  logic w_stb, w_err, w_dir_nxt, w_stall_nxt;
  logic [PERIOD_W-1:0] w_pcnt_nxt;

`ifdef HALL_INV_EN
  assign w_raw = ~hall_raw;
`else
  assign w_raw = hall_raw;
`endif

  // Synchroniser and stability filter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_cand  <= '0;
      r_fcnt  <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        r_fcnt <= '0;
      end else if (r_fcnt != FILT_MAX) begin
        r_fcnt <= r_fcnt + FCW'(1);
      end
    end
  end

  // Accept on the sample that completes FILT_CYCLES stable samples
  assign w_acc       = (r_sync2 == r_cand) && (r_fcnt == FILT_ACC) && (r_cand != h);
  assign w_new_v     = (r_cand != 3'd0) && (r_cand != 3'd7);
  assign w_is_fwd    = (r_cand == fwd_of(h));
  assign w_is_rev    = (r_cand == rev_of(h));
  assign w_legal     = w_acc && hall_valid && w_new_v && (w_is_fwd || w_is_rev);
  assign w_illegal   = w_acc && hall_valid && w_new_v && !(w_is_fwd || w_is_rev);
  assign w_entry     = w_acc && !hall_valid && w_new_v;
  assign w_exit      = w_acc && !w_new_v;
  assign w_vedge     = w_acc && w_new_v;
  assign w_stall_hit = (r_pcnt == LIM_M1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_INIT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_exit) begin
      w_state_nxt = ST_INIT;
    end else if (w_illegal || w_entry) begin
      w_state_nxt = ST_SYNC;
    end else if (w_legal) begin
      // A legal edge coinciding with the stall threshold only re-synchronises
      if (w_stall_hit || (r_state == ST_INIT)) w_state_nxt = ST_SYNC;
      else                                     w_state_nxt = ST_RUN;
    end else if (w_stall_hit) begin
      w_state_nxt = ST_SYNC;
    end
  end

  always_comb begin
    w_stb       = w_legal && !w_stall_hit && (r_state == ST_RUN);
    w_err       = w_illegal;
    w_dir_nxt   = dir_obs;
    w_stall_nxt = stall;
    w_pcnt_nxt  = r_pcnt;
    if (w_legal) w_dir_nxt = w_is_rev;
    if (w_vedge)          w_stall_nxt = 1'b0;
    else if (w_stall_hit) w_stall_nxt = 1'b1;
    if (w_vedge)          w_pcnt_nxt = PERIOD_W'(1);
    else if (r_pcnt != LIM) w_pcnt_nxt = r_pcnt + PERIOD_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h          <= '0;
      hall_valid <= 1'b0;
      dir_obs    <= 1'b0;
      period     <= '0;
      period_stb <= 1'b0;
      stall      <= 1'b0;
      seq_err    <= 1'b0;
      r_pcnt     <= '0;
    end else begin
      if (w_acc) begin
        h          <= r_cand;
        hall_valid <= w_new_v;
      end
      if (w_stb) period <= r_pcnt;
      dir_obs    <= w_dir_nxt;
      period_stb <= w_stb;
      stall      <= w_stall_nxt;
      seq_err    <= w_err;
      r_pcnt     <= w_pcnt_nxt;
    end
  end

endmodule
